// File: rtl/dmux_tx_if.sv
// Requester/channel bundle for dmux_tx_arbiter.
//   req, req_data  : per-requester request levels and packed data (requester k at [k*DW +: DW])
//   ack, grant_id  : one-cycle ack to the launched requester, index of current/last grant
//   data_in, data_in_valid : drive the CDC data-mux channel inputs
// master = requester/channel side, slave = arbiter side.
interface dmux_tx_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = 8
);
    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    ack;
    logic [GW-1:0]         grant_id;
    logic [DW-1:0]         data_in;
    logic                  data_in_valid;

    modport master (
        output req, req_data,
        input  ack, grant_id, data_in, data_in_valid
    );

    modport slave (
        input  req, req_data,
        output ack, grant_id, data_in, data_in_valid
    );
endinterface

// File: rtl/dmux_tx_arbiter.sv
// Round-robin scheduler sharing one CDC data-mux channel among NUM_REQ requesters.
// Each launch: data_in latched at grant, held SETUP_CYC cycles, one-cycle valid pulse
// with ack to the winner, then held HOLD_CYC more cycles before the next grant.
//   clk_a  : source-domain clock
//   rst    : synchronous active-high reset
//   enable : gates new grants only; an in-flight transfer always completes
//   busy   : high whenever the scheduler is not idle
//   bus    : requester/channel bundle (slave side)
module dmux_tx_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned HOLD_CYC  = 8
) (
    input  logic     clk_a,
    input  logic     rst,
    input  logic     enable,
    output logic     busy,
    dmux_tx_if.slave bus
);
    localparam int unsigned GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CMAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state_q, state_n;
    logic [CW-1:0]      cnt_q, cnt_n;
    logic [GW-1:0]      ptr_q, ptr_n;
    logic [GW-1:0]      grant_q, grant_n;
    logic [DW-1:0]      data_q, data_n;
    logic               valid_q, valid_n;
    logic [NUM_REQ-1:0] ack_q, ack_n;
    logic               busy_q, busy_n;

    logic               pick_found;
    logic [GW-1:0]      pick_idx;
    logic [DW-1:0]      req_word [NUM_REQ];

    // Unpack requester data words
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_word[k] = bus.req_data[k*DW +: DW];
    end

    // First set request searching upward from the pointer, wrapping at NUM_REQ
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!pick_found && bus.req[GW'(idx)]) begin
                pick_found = 1'b1;
                pick_idx   = GW'(idx);
            end
        end
    end

    // Next-state and next-output logic; outputs are registered from these
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        ptr_n   = ptr_q;
        grant_n = grant_q;
        data_n  = data_q;
        valid_n = 1'b0;
        ack_n   = '0;

        case (state_q)
            IDLE: begin
                if (enable && pick_found) begin
                    state_n = SETUP;
                    cnt_n   = '0;
                    grant_n = pick_idx;
                    data_n  = req_word[pick_idx];
                end
            end
            SETUP: begin
                if (cnt_q == CW'(SETUP_CYC - 1)) begin
                    state_n        = PULSE;
                    valid_n        = 1'b1;
                    ack_n[grant_q] = 1'b1;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            PULSE: begin
                state_n = HOLD;
                cnt_n   = '0;
                ptr_n   = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
            end
            HOLD: begin
                if (cnt_q == CW'(HOLD_CYC - 1)) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_a) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            ptr_q   <= ptr_n;
            grant_q <= grant_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            ack_q   <= ack_n;
            busy_q  <= busy_n;
        end
    end

    assign bus.ack           = ack_q;
    assign bus.grant_id      = grant_q;
    assign bus.data_in       = data_q;
    assign bus.data_in_valid = valid_q;
    assign busy              = busy_q;
endmodule

// File: tb/tb_dmux_tx_arbiter.sv
// Scoreboard bench for dmux_tx_arbiter: stimulus pushes expected launches
// (requester, data, cycle); a negedge monitor pops them on each valid pulse.
module tb_dmux_tx_arbiter;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DW      = 8;
    localparam int unsigned HOLD    = 8;

    typedef struct {
        int          id;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    logic enable;
    logic busy;

    dmux_tx_if #(.NUM_REQ(NUM_REQ), .DW(DW)) bus ();

    dmux_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .DW(DW), .SETUP_CYC(2), .HOLD_CYC(HOLD)
    ) dut (
        .clk_a  (clk),
        .rst    (rst),
        .enable (enable),
        .busy   (busy),
        .bus    (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int id, input logic [7:0] data, input int c);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.req  = '0;
        tick(3);
        rst      = 1'b0;
    endtask

    task automatic wait_ack(input int k, input int budget);
        int n;
        n = 0;
        while (!bus.ack[k] && n < budget) begin
            tick(1);
            n++;
        end
        chk("ack_wait", 32'(bus.ack[k]), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            tick(1);
            n++;
        end
        chk("idle_wait", 32'(busy), 32'd0);
        chk("exp_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every pulse must match the next expected launch; ack only with valid;
    // data stable two cycles before and HOLD cycles after each pulse.
    logic [7:0] hist1, hist2, hold_val;
    int         hold_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_cnt = 0;
        end else if (bus.data_in_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'(bus.data_in), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_data", 32'(bus.data_in), 32'(e.data));
                chk("pulse_grant", 32'(bus.grant_id), 32'(e.id));
                chk("pulse_ack", 32'(bus.ack), 32'(1) << e.id);
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                chk("setup_stable1", 32'(hist1), 32'(e.data));
                chk("setup_stable2", 32'(hist2), 32'(e.data));
                hold_val = e.data;
                hold_cnt = HOLD;
            end
        end else begin
            chk("ack_no_valid", 32'(bus.ack), 32'd0);
            if (hold_cnt > 0) begin
                chk("hold_stable", 32'(bus.data_in), 32'(hold_val));
                hold_cnt--;
            end
        end
        hist2 = hist1;
        hist1 = bus.data_in;
    end

    initial begin
        int base;
        rst          = 1'b1;
        enable       = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;

        // Reset state
        tick(3);
        chk("rst_valid", 32'(bus.data_in_valid), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(bus.data_in), 32'd0);
        chk("rst_grant", 32'(bus.grant_id), 32'd0);
        rst = 1'b0;
        tick(1);

        // Single request on requester 1
        base = cyc;
        bus.req_data[1*DW +: DW] = 8'h36;
        bus.req = 4'b0010;
        push(1, 8'h36, base + 3);
        for (int c = 1; c <= 12; c++) begin
            tick(1);
            if (c == 3) bus.req = '0;
            chk("t1_data", 32'(bus.data_in), 32'h36);
            chk("t1_busy", 32'(busy), (c < 12) ? 32'd1 : 32'd0);
        end
        chk("t1_grant", 32'(bus.grant_id), 32'd1);
        wait_idle(20);

        // All four requesters, each held until its ack
        do_reset();
        base = cyc;
        bus.req_data = {8'h40, 8'h30, 8'h20, 8'h10};
        bus.req = 4'b1111;
        push(0, 8'h10, base + 3);
        push(1, 8'h20, base + 15);
        push(2, 8'h30, base + 27);
        push(3, 8'h40, base + 39);
        for (int k = 0; k < 4; k++) begin
            wait_ack(k, 20);
            bus.req[k] = 1'b0;
        end
        wait_idle(20);

        // Fairness: requesters 0 and 2 held continuously
        do_reset();
        base = cyc;
        bus.req_data = {8'h00, 8'hC2, 8'h00, 8'hA0};
        bus.req = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            push((i % 2 == 0) ? 0 : 2, (i % 2 == 0) ? 8'hA0 : 8'hC2, base + 3 + 12 * i);
        end
        for (int i = 0; i < 6; i++) begin
            wait_ack((i % 2 == 0) ? 0 : 2, 20);
        end
        bus.req = '0;
        wait_idle(20);

        // Reset in SETUP of a requester-3 transfer, then 0 and 3 together
        do_reset();
        base = cyc;
        bus.req_data = {8'h54, 8'h00, 8'h00, 8'h0F};
        bus.req = 4'b1000;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_valid", 32'(bus.data_in_valid), 32'd0);
        chk("mid_rst_ack", 32'(bus.ack), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", 32'(bus.data_in), 32'd0);
        chk("mid_rst_grant", 32'(bus.grant_id), 32'd0);
        bus.req = 4'b1001;
        push(0, 8'h0F, base + 6);
        push(3, 8'h54, base + 18);
        wait_ack(0, 10);
        bus.req[0] = 1'b0;
        wait_ack(3, 20);
        bus.req[3] = 1'b0;
        wait_idle(20);

        // Enable gating
        do_reset();
        enable = 1'b0;
        bus.req_data = {8'h00, 8'h2D, 8'h77, 8'h00};
        bus.req = 4'b0100;
        tick(10);
        chk("gated_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        push(2, 8'h2D, cyc + 3);
        wait_ack(2, 10);
        bus.req = '0;
        tick(1);
        enable  = 1'b0;
        bus.req = 4'b0010;
        tick(20);
        chk("gated_done_busy", 32'(busy), 32'd0);
        chk("gated_done_grant", 32'(bus.grant_id), 32'd2);
        bus.req = '0;
        enable  = 1'b1;
        wait_idle(20);

        // Late data change and request withdrawal after grant
        do_reset();
        base = cyc;
        bus.req_data[0 +: DW] = 8'h11;
        bus.req = 4'b0001;
        push(0, 8'h11, base + 3);
        tick(1);
        bus.req_data[0 +: DW] = 8'h99;
        tick(1);
        bus.req = '0;
        wait_ack(0, 5);
        wait_idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
